// File: rtl/fir_serial_mac_pkg.sv
// Shared FSM state encoding and sizing helpers for the serial-MAC FIR filter.
package fir_serial_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_e;

  // Ceiling log2 with a floor of one bit so single-entry ranges still get a real vector.
  function automatic int unsigned fir_clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned w = 1; w < 32; w++) begin
      if ((64'd1 << w) < 64'(value)) width = w + 1;
    end
    return width;
  endfunction

  // Accumulator width: full product, growth over all taps, plus one bit for the fold pre-adder.
  function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + fir_clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/fir_serial_mac_mac_unit.sv
// Single shared multiplier feeding a clearable, enabled accumulator register.
module fir_serial_mac_mac_unit #(
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 16,
  parameter int unsigned ACC_W = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] acc
);

  localparam int unsigned PROD_W = A_W + B_W;

  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;

  // Clear has priority so a new computation never inherits a stale product.
  always_comb begin : acc_next
    prod_c = PROD_W'(a) * PROD_W'(b);
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod_c);
    end
  end

  always_ff @(posedge clk) begin : acc_reg
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_serial_mac.sv
// Resource-shared FIR: one multiplier and accumulator time-multiplexed over all taps.
// Build option: define SYMMETRIC_FOLD_EN for even-symmetric coefficients with a pre-adder.
module fir_serial_mac
  import fir_serial_mac_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 19,
  parameter int unsigned OUT_SHIFT = 17
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [DATA_W-1:0]          IN_DATA,
  input  logic                       COEF_WE,
  input  logic [fir_clog2(TAPS)-1:0] COEF_ADDR,
  input  logic [COEF_W-1:0]          COEF_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [DATA_W-1:0]          OUT_DATA
);

  localparam int unsigned AW    = fir_clog2(TAPS);
  localparam int unsigned ACC_W = fir_acc_w(DATA_W, COEF_W, TAPS);
  localparam int unsigned SUM_W = ACC_W + 1;
`ifdef SYMMETRIC_FOLD_EN
  localparam int unsigned NCOEF = (TAPS + 1) / 2;
  localparam int unsigned XW    = DATA_W + 1;
`else
  localparam int unsigned NCOEF = TAPS;
  localparam int unsigned XW    = DATA_W;
`endif
  localparam int unsigned CW    = fir_clog2(NCOEF + 1);
  localparam int unsigned PW    = fir_clog2(TAPS);
  localparam int unsigned RND_POS = (OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1;
  localparam logic [SUM_W-1:0] RND_HALF = (OUT_SHIFT == 0) ? '0 : (SUM_W'(1) << RND_POS);

  fir_state_e        state_q, state_d;
  logic [DATA_W-1:0] x_q    [TAPS];
  logic [DATA_W-1:0] x_d    [TAPS];
  logic [COEF_W-1:0] coef_q [NCOEF];
  logic [COEF_W-1:0] coef_d [NCOEF];
  logic [CW-1:0]     tap_q, tap_d;
  logic [PW-1:0]     prime_q, prime_d;
  logic [XW-1:0]     op_x_q, op_x_d;
  logic [COEF_W-1:0] op_c_q, op_c_d;
  logic              op_v_q, op_v_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              accept_c;
  logic              mac_clr_c;
  logic [ACC_W-1:0]  acc;
  logic [SUM_W-1:0]  rnd_sum_c;
  logic [SUM_W-1:0]  rnd_shr_c;
  logic [DATA_W-1:0] sat_c;

  // Operand fetch for the current tap; registered so the wide delay-line mux is off the multiplier path.
  always_comb begin : fetch
    op_x_d = '0;
    op_c_d = '0;
    for (int unsigned k = 0; k < NCOEF; k++) begin
      if (tap_q == CW'(k)) begin
        op_c_d = coef_q[k];
`ifdef SYMMETRIC_FOLD_EN
        if (2 * k + 1 == TAPS) begin
          op_x_d = XW'(x_q[k]);
        end else begin
          op_x_d = XW'(x_q[k]) + XW'(x_q[TAPS-1-k]);
        end
`else
        op_x_d = x_q[k];
`endif
      end
    end
  end

  fir_serial_mac_mac_unit #(
    .A_W   (XW),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (CLK),
    .rst (RST),
    .clr (mac_clr_c),
    .en  (op_v_q),
    .a   (op_x_q),
    .b   (op_c_q),
    .acc (acc)
  );

  // Round half-up, shift down, clamp to all-ones on overflow.
  always_comb begin : round_sat
    rnd_sum_c = SUM_W'(acc) + RND_HALF;
    rnd_shr_c = rnd_sum_c >> OUT_SHIFT;
    sat_c     = rnd_shr_c[DATA_W-1:0];
    if (|rnd_shr_c[SUM_W-1:DATA_W]) begin
      sat_c = '1;
    end
  end

  // MAC state issues NCOEF fetches plus one drain cycle while the last product lands.
  always_comb begin : fsm
    state_d     = state_q;
    x_d         = x_q;
    coef_d      = coef_q;
    tap_d       = tap_q;
    prime_d     = prime_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mac_clr_c   = 1'b0;
    accept_c    = in_ready_q && IN_VALID;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          for (int unsigned i = TAPS - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]    = IN_DATA;
          tap_d     = '0;
          mac_clr_c = 1'b1;
          state_d   = ST_MAC;
        end else if (COEF_WE) begin
          for (int unsigned k = 0; k < NCOEF; k++) begin
            if (COEF_ADDR == AW'(k)) coef_d[k] = COEF_DATA;
          end
        end
      end
      ST_MAC: begin
        if (tap_q == CW'(NCOEF)) begin
          state_d = ST_ROUND;
        end else begin
          tap_d = tap_q + CW'(1);
        end
      end
      ST_ROUND: begin
        if (prime_q < PW'(TAPS - 1)) begin
          prime_d = prime_q + PW'(1);
          state_d = ST_IDLE;
        end else begin
          out_data_d  = sat_c;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    op_v_d     = (state_q == ST_MAC) && (tap_q != CW'(NCOEF));
  end

  always_ff @(posedge CLK) begin : regs
    if (RST) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      prime_q     <= '0;
      op_x_q      <= '0;
      op_c_q      <= '0;
      op_v_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int unsigned i = 0; i < TAPS; i++) x_q[i] <= '0;
      for (int unsigned i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      prime_q     <= prime_d;
      op_x_q      <= op_x_d;
      op_c_q      <= op_c_d;
      op_v_q      <= op_v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: a default 19-tap instance and a 4-tap, no-shift instance
// checked against a direct-form filter equation with priming and rounding rules.
`timescale 1ns/1ps
module tb_fir_serial_mac;
  localparam int NDUT = 2;
  localparam int MAXT = 19;
`ifdef SYMMETRIC_FOLD_EN
  localparam int IMP_ADDR = 1;
`else
  localparam int IMP_ADDR = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [15:0] in_data   [NDUT];
  logic        coef_we   [NDUT];
  logic [15:0] coef_data [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [15:0] out_data  [NDUT];
  logic [4:0]  a_coef_addr;
  logic [1:0]  b_coef_addr;

  fir_serial_mac dut_a (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .IN_DATA(in_data[0]),
    .COEF_WE(coef_we[0]), .COEF_ADDR(a_coef_addr), .COEF_DATA(coef_data[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .OUT_DATA(out_data[0])
  );

  fir_serial_mac #(.DATA_W(16), .COEF_W(16), .TAPS(4), .OUT_SHIFT(0)) dut_b (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .IN_DATA(in_data[1]),
    .COEF_WE(coef_we[1]), .COEF_ADDR(b_coef_addr), .COEF_DATA(coef_data[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .OUT_DATA(out_data[1])
  );

  longint unsigned hist  [NDUT][MAXT];
  longint unsigned cf    [NDUT][MAXT];
  int              n_acc [NDUT];
  int              checks = 0;
  int              errors = 0;
  int unsigned     base_c [10] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660};

  function automatic int taps_of(input int s);
    return (s == 0) ? 19 : 4;
  endfunction

  function automatic int shift_of(input int s);
    return (s == 0) ? 17 : 0;
  endfunction

  function automatic int ncoef_of(input int s);
`ifdef SYMMETRIC_FOLD_EN
    return (taps_of(s) + 1) / 2;
`else
    return taps_of(s);
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NDUT; s++) begin
      n_acc[s] = 0;
      for (int k = 0; k < MAXT; k++) begin
        hist[s][k] = 0;
        cf[s][k]   = 0;
      end
    end
  endtask

  task automatic model_coef(input int s, input int addr, input logic [15:0] data);
    if (addr < ncoef_of(s)) begin
      cf[s][addr] = longint'(data);
`ifdef SYMMETRIC_FOLD_EN
      cf[s][taps_of(s) - 1 - addr] = longint'(data);
`endif
    end
  endtask

  task automatic model_accept(input int s, input logic [15:0] d);
    for (int k = taps_of(s) - 1; k > 0; k--) hist[s][k] = hist[s][k-1];
    hist[s][0] = longint'(d);
    n_acc[s]++;
  endtask

  function automatic longint unsigned model_out(input int s);
    longint unsigned acc;
    acc = 0;
    for (int k = 0; k < taps_of(s); k++) acc += cf[s][k] * hist[s][k];
    if (shift_of(s) > 0) acc += 64'd1 << (shift_of(s) - 1);
    acc = acc >> shift_of(s);
    if (acc > 64'd65535) acc = 64'd65535;
    return acc;
  endfunction

  task automatic set_addr(input int s, input int addr);
    if (s == 0) a_coef_addr = 5'(addr);
    else        b_coef_addr = 2'(addr);
  endtask

  task automatic coef_wr(input int s, input int addr, input logic [15:0] data);
    coef_we[s]   = 1'b1;
    coef_data[s] = data;
    set_addr(s, addr);
    @(posedge clk); #1;
    coef_we[s] = 1'b0;
    model_coef(s, (s == 0) ? (addr & 31) : (addr & 3), data);
  endtask

  // we_mode: 0 none, 1 write alongside the accept, 2 write during the MAC phase.
  task automatic push(input int s, input logic [15:0] d, input int rdly, input int we_mode,
                      output logic [15:0] got);
    int          n;
    bit          saw_ov;
    logic [15:0] exp_d;
    int          exp_lat;
    exp_lat = ncoef_of(s) + 2;
    got     = '0;
    n       = 0;
    while (in_ready[s] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait dut%0d got %b exp 1", s, in_ready[s]);
    end
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    if (we_mode == 1) begin
      coef_we[s] = 1'b1; coef_data[s] = 16'hffff; set_addr(s, 0);
    end
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    coef_we[s]  = 1'b0;
    model_accept(s, d);
    n      = 0;
    saw_ov = 1'b0;
    if (we_mode == 2) begin
      coef_we[s] = 1'b1; coef_data[s] = 16'hffff; set_addr(s, 0);
      repeat (2) begin
        @(posedge clk); #1; n++;
        saw_ov = saw_ov | (out_valid[s] === 1'b1);
      end
      coef_we[s] = 1'b0;
    end
    if (n_acc[s] >= taps_of(s)) begin
      exp_d = 16'(model_out(s));
      while (out_valid[s] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      got = out_data[s];
      checks++;
      if (n != exp_lat || saw_ov) begin
        errors++;
        $display("FAIL latency dut%0d got %0d exp %0d (early valid %0b)", s, n, exp_lat, saw_ov);
      end
      checks++;
      if (out_data[s] !== exp_d) begin
        errors++;
        $display("FAIL out_data dut%0d sample %0d got %0d exp %0d", s, n_acc[s], out_data[s], exp_d);
      end
      for (int i = 0; i < rdly; i++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid[s] !== 1'b1 || in_ready[s] !== 1'b0 || out_data[s] !== exp_d) begin
          errors++;
          $display("FAIL hold dut%0d got valid %b ready %b data %0d exp 1 0 %0d",
                   s, out_valid[s], in_ready[s], out_data[s], exp_d);
        end
      end
      out_ready[s] = 1'b1;
      @(posedge clk); #1;
      out_ready[s] = 1'b0;
      checks++;
      if (out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL release dut%0d got valid %b ready %b exp 0 1", s, out_valid[s], in_ready[s]);
      end
    end else begin
      while (in_ready[s] !== 1'b1 && n < 100) begin
        @(posedge clk); #1; n++;
        saw_ov = saw_ov | (out_valid[s] === 1'b1);
      end
      checks++;
      if (n != exp_lat || saw_ov) begin
        errors++;
        $display("FAIL prime_skip dut%0d got cycles %0d valid %0b exp %0d 0", s, n, saw_ov, exp_lat);
      end
    end
  endtask

  task automatic load_mirror();
    for (int k = 0; k < 19; k++) coef_wr(0, k, 16'(base_c[(k < 10) ? k : 18 - k]));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < NDUT; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got %b exp 1", s, in_ready[s]); end
      checks++;
      if (out_valid[s] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got %b exp 0", s, out_valid[s]); end
      checks++;
      if (out_data[s] !== 16'd0) begin errors++; $display("FAIL reset_out_data dut%0d got %0d exp 0", s, out_data[s]); end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_dc_1000();
    logic [15:0] got;
    load_mirror();
    for (int i = 0; i < 22; i++) push(0, 16'd1000, 0, 0, got);
    checks++;
    if (got !== 16'd1121) begin errors++; $display("FAIL dc_1000 got %0d exp 1121", got); end
  endtask

  task automatic test_dc_sat();
    logic [15:0] got;
    for (int i = 0; i < 19; i++) push(0, 16'd65535, 0, 0, got);
    checks++;
    if (got !== 16'd65535) begin errors++; $display("FAIL dc_sat got %0d exp 65535", got); end
  endtask

  task automatic test_coef_drop();
    logic [15:0] got;
    for (int i = 0; i < 19; i++) push(0, 16'd1000, 0, (i % 3 == 2) ? 0 : (i % 3) + 1, got);
    checks++;
    if (got !== 16'd1121) begin errors++; $display("FAIL coef_drop got %0d exp 1121", got); end
  endtask

  task automatic test_backpressure();
    logic [15:0] got;
    for (int i = 0; i < 3; i++) begin
      push(0, 16'($urandom_range(0, 65535)), 10, 0, got);
      repeat (3) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL extra_output got %b exp 0", out_valid[0]); end
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] got;
    logic [15:0] seq [5];
    coef_wr(1, IMP_ADDR, 16'd5);
    for (int i = 0; i < 3; i++) push(1, 16'd0, 0, 0, got);
    push(1, 16'd7, 1, 0, seq[0]);
    for (int i = 1; i < 5; i++) push(1, 16'd0, 0, 0, seq[i]);
    checks++;
    if (seq[2] !== 16'd35) begin errors++; $display("FAIL impulse got %0d exp 35", seq[2]); end
  endtask

  task automatic test_rst_mid();
    logic [15:0] got;
    in_valid[0] = 1'b1; in_data[0] = 16'd1234;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ready %b valid %b exp 1 0", in_ready[0], out_valid[0]);
    end
    model_reset();
    load_mirror();
    for (int i = 0; i < 19; i++) push(0, 16'd1000, 0, 0, got);
    checks++;
    if (got !== 16'd1121) begin errors++; $display("FAIL rst_reprime got %0d exp 1121", got); end
  endtask

  task automatic test_random();
    logic [15:0] got;
    for (int s = 0; s < NDUT; s++) begin
      for (int i = 0; i < 8; i++) begin
        coef_wr(s, $urandom_range(0, (s == 0) ? 31 : 3),
                16'((s == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 255)));
      end
      for (int i = 0; i < 25; i++) begin
        push(s, 16'((s == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 255)),
             $urandom_range(0, 3), $urandom_range(0, 2), got);
      end
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1;
    a_coef_addr = '0;
    b_coef_addr = '0;
    for (int s = 0; s < NDUT; s++) begin
      in_valid[s] = 1'b0; in_data[s] = '0; coef_we[s] = 1'b0;
      coef_data[s] = '0; out_ready[s] = 1'b0;
    end
    test_reset();
    test_dc_1000();
    test_dc_sat();
    test_coef_drop();
    test_backpressure();
    test_impulse();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
